// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared bus widths, access-size encodings and FSM states for the memory stage.
package mem_access_unit_pkg;
   localparam int DATA_BUS = 32;
   localparam int ADDR_BUS = 32;
   localparam int MEM_SEL_BUS = 4;
   localparam int REG_ADDR_BUS = 5;
   localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
   localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
   localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: shifts read data down to the accessed byte lane, masks to size and optionally sign-extends.
module mem_load_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]             addr,
   input  logic [MEM_SEL_BUS-1:0] sel,
   input  logic                   sign_ext,
   input  logic [DATA_BUS-1:0]    rdata,
   output logic [DATA_BUS-1:0]    data
);
   logic [DATA_BUS-1:0] shifted;
   always_comb begin
      shifted = rdata >> {addr, 3'b000};
      data = sel == MEM_SEL_BYTE ? {{24{sign_ext & shifted[7]}}, shifted[7:0]} :
             sel == MEM_SEL_HALF ? {{16{sign_ext & shifted[15]}}, shifted[15:0]} : shifted;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage bus master running each load/store as a stalled request/response transaction.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_read_flag,
   input  logic                    mem_write_flag,
   input  logic                    mem_sign_ext_flag,
   input  logic [MEM_SEL_BUS-1:0]  mem_sel,
   input  logic [DATA_BUS-1:0]     mem_write_data,
   input  logic [DATA_BUS-1:0]     result_in,
   input  logic                    reg_write_en_in,
   input  logic [REG_ADDR_BUS-1:0] reg_write_addr_in,
   input  logic [ADDR_BUS-1:0]     current_pc_addr_in,
   output logic                    stall_req,
   output logic                    addr_error,
   output logic                    ram_req,
   output logic                    ram_wr,
   output logic [ADDR_BUS-1:0]     ram_addr,
   output logic [MEM_SEL_BUS-1:0]  ram_wen,
   output logic [DATA_BUS-1:0]     ram_wdata,
   input  logic                    ram_addr_ok,
   input  logic                    ram_data_ok,
   input  logic [DATA_BUS-1:0]     ram_rdata,
   output logic [DATA_BUS-1:0]     result,
   output logic                    reg_write_en_out,
   output logic [REG_ADDR_BUS-1:0] reg_write_addr_out,
   output logic [ADDR_BUS-1:0]     current_pc_addr_out
);
   state_t state, next;
   logic access, misaligned, go, capture;
   logic [MEM_SEL_BUS-1:0] wen;
   logic [DATA_BUS-1:0] wdata, load_data, load_q;
   mem_load_align align (
      .addr     (result_in[1:0]),
      .sel      (mem_sel),
      .sign_ext (mem_sign_ext_flag),
      .rdata    (ram_rdata),
      .data     (load_data)
   );
   always_comb begin
      access = mem_read_flag | mem_write_flag;
      misaligned = (mem_sel == MEM_SEL_HALF & result_in[0]) | (mem_sel == MEM_SEL_WORD & result_in[1:0] != 2'b00);
      addr_error = ~rst & access & misaligned;
      go = access & ~misaligned;
      wen = mem_sel << result_in[1:0];
      wdata = mem_sel == MEM_SEL_BYTE ? {4{mem_write_data[7:0]}} :
              mem_sel == MEM_SEL_HALF ? {2{mem_write_data[15:0]}} : mem_write_data;
      // a coincident addr_ok/data_ok in REQ completes the transfer without visiting WAIT
      capture = ram_data_ok & (state == WAIT | (state == REQ & ram_addr_ok));
      ram_req = state == REQ;
      stall_req = state == IDLE ? go : state != DONE;
      result = state == DONE & mem_read_flag ? load_q : result_in;
      reg_write_en_out = reg_write_en_in & ~mem_write_flag & ~addr_error;
      reg_write_addr_out = reg_write_addr_in;
      current_pc_addr_out = current_pc_addr_in;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = go ? REQ : IDLE;
         REQ:     next = ram_addr_ok ? (ram_data_ok ? DONE : WAIT) : REQ;
         WAIT:    next = ram_data_ok ? DONE : WAIT;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         load_q <= '0;
         ram_wr <= 1'b0;
         ram_wen <= '0;
         ram_addr <= '0;
         ram_wdata <= '0;
      end else begin
         state <= next;
         if (state == IDLE & go) begin
            ram_addr <= {result_in[ADDR_BUS-1:2], 2'b00};
            ram_wr <= mem_write_flag;
            ram_wen <= mem_write_flag ? wen : '0;
            ram_wdata <= wdata;
         end
         if (capture) load_q <= load_data;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed loads/stores against a scripted bus slave; a monitor scores each retiring instruction.
module tb_mem_access_unit;
   logic clk = 0, rst = 1;
   logic mem_read_flag = 0, mem_write_flag = 0, mem_sign_ext_flag = 0;
   logic [3:0] mem_sel = 0;
   logic [31:0] mem_write_data = 0, result_in = 0, current_pc_addr_in = 0;
   logic reg_write_en_in = 0;
   logic [4:0] reg_write_addr_in = 0;
   logic stall_req, addr_error, ram_req, ram_wr, reg_write_en_out;
   logic [31:0] ram_addr, ram_wdata, result, current_pc_addr_out;
   logic [3:0] ram_wen;
   logic [4:0] reg_write_addr_out;
   logic ram_addr_ok = 0, ram_data_ok = 0;
   logic [31:0] ram_rdata = 0;
   typedef struct {
      logic [31:0] res;
      logic        we;
      logic        err;
      logic [4:0]  wa;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, fails = 0, seq = 0;
   logic inst_valid = 0;
   always #5 clk = ~clk;
   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
      .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
      .mem_write_data(mem_write_data), .result_in(result_in),
      .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
      .current_pc_addr_in(current_pc_addr_in), .stall_req(stall_req),
      .addr_error(addr_error), .ram_req(ram_req), .ram_wr(ram_wr),
      .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
      .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata),
      .result(result), .reg_write_en_out(reg_write_en_out),
      .reg_write_addr_out(reg_write_addr_out), .current_pc_addr_out(current_pc_addr_out)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask
   // an instruction retires on the one cycle it is presented with stall_req low
   always @(negedge clk) begin
      if (inst_valid && !stall_req) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_retire: got result 0x%08h, expected no retirement", result);
         end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("reg_write_en_out", {31'b0, reg_write_en_out}, {31'b0, e.we});
            chk("addr_error", {31'b0, addr_error}, {31'b0, e.err});
            chk("reg_write_addr_out", {27'b0, reg_write_addr_out}, {27'b0, e.wa});
            chk("current_pc_addr_out", current_pc_addr_out, e.pc);
         end
      end
   end
   task automatic issue(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [31:0] exp_res, input int acyc, input logic coinc,
                        input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                        input int exp_req, input int exp_stall, input logic exp_we, input logic exp_err);
      int nreq, nstall;
      logic pend, done;
      logic [31:0] pc;
      nreq = 0; nstall = 0; pend = 0; done = 0;
      pc = 32'h400 + seq * 4;
      mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sx; mem_sel = sel;
      mem_write_data = wd; result_in = addr; reg_write_en_in = 1;
      reg_write_addr_in = seq[4:0]; current_pc_addr_in = pc;
      sb.push_back('{exp_res, exp_we, exp_err, seq[4:0], pc});
      inst_valid = 1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (ram_req) begin
            nreq++;
            if (nreq == 1) begin
               chk("ram_addr", ram_addr, {addr[31:2], 2'b00});
               chk("ram_wen", {28'b0, ram_wen}, {28'b0, exp_wen});
               chk("ram_wr", {31'b0, ram_wr}, {31'b0, wr});
               if (wr) chk("ram_wdata", ram_wdata, exp_wdata);
            end
            if (nreq == acyc) begin
               ram_addr_ok = 1; ram_data_ok = coinc; ram_rdata = rdata;
            end
         end else if (pend) begin
            ram_data_ok = 1; ram_rdata = rdata; pend = 0;
         end
         if (!stall_req) done = 1;
         else begin
            nstall++;
            @(posedge clk); #1;
            pend = pend | (ram_addr_ok & ~ram_data_ok);
            ram_addr_ok = 0; ram_data_ok = 0;
         end
      end
      if (!done) begin
         checks++;
         fails++;
         $display("FAIL timeout: instruction %0d still stalled after 40 cycles, expected retirement", seq);
      end
      chk("req_cycles", nreq, exp_req);
      chk("stall_cycles", nstall, exp_stall);
      @(posedge clk); #1;
      seq++;
   endtask
   task automatic reset_in_wait();
      inst_valid = 0;
      mem_read_flag = 1; mem_write_flag = 0; mem_sel = 4'b1111; result_in = 32'hB004;
      @(negedge clk);
      chk("rw_idle_req", {31'b0, ram_req}, 0);
      chk("rw_idle_stall", {31'b0, stall_req}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw_req", {31'b0, ram_req}, 1);
      ram_addr_ok = 1;
      @(posedge clk); #1;
      ram_addr_ok = 0;
      @(negedge clk);
      chk("rw_wait_req", {31'b0, ram_req}, 0);
      chk("rw_wait_stall", {31'b0, stall_req}, 1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rw_after_rst_req", {31'b0, ram_req}, 0);
      chk("rw_after_rst_addr", ram_addr, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw_restart_req", {31'b0, ram_req}, 1);
      chk("rw_restart_addr", ram_addr, 32'hB004);
      rst = 1;
      @(posedge clk); #1;
      rst = 0; mem_read_flag = 0;
      @(negedge clk);
      chk("rst_in_req_req", {31'b0, ram_req}, 0);
      chk("rst_in_req_stall", {31'b0, stall_req}, 0);
      @(posedge clk); #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ram_req", {31'b0, ram_req}, 0);
      chk("rst_ram_wr", {31'b0, ram_wr}, 0);
      chk("rst_ram_wen", {28'b0, ram_wen}, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_addr_error", {31'b0, addr_error}, 0);
      chk("rst_stall", {31'b0, stall_req}, 0);
      @(posedge clk); #1;
      rst = 0;
      //    rd wr sx sel      wdata         addr          rdata         exp_res       acyc co wen      exp_wdata     req st we err
      issue(0, 0, 0, 4'b1111, 32'h0,        32'h00001234, 32'h0,        32'h00001234, 1, 0, 4'b0000, 32'h0,        0, 0, 1, 0);
      issue(1, 0, 1, 4'b0001, 32'h0,        32'h00001003, 32'h80AABBCC, 32'hFFFFFF80, 1, 0, 4'b0000, 32'h0,        1, 3, 1, 0);
      issue(0, 1, 0, 4'b0011, 32'h0000BEEF, 32'h00002002, 32'h0,        32'h00002002, 3, 0, 4'b1100, 32'hBEEFBEEF, 3, 5, 0, 0);
      issue(1, 0, 0, 4'b1111, 32'h0,        32'h00003001, 32'h0,        32'h00003001, 1, 0, 4'b0000, 32'h0,        0, 0, 0, 1);
      issue(1, 0, 0, 4'b0011, 32'h0,        32'h00004000, 32'hFFFF8001, 32'h00008001, 1, 1, 4'b0000, 32'h0,        1, 2, 1, 0);
      reset_in_wait();
      issue(0, 1, 0, 4'b0011, 32'h00001111, 32'h00005003, 32'h0,        32'h00005003, 1, 0, 4'b0000, 32'h0,        0, 0, 0, 1);
      issue(1, 0, 1, 4'b0011, 32'h0,        32'h00006002, 32'h80011234, 32'hFFFF8001, 1, 0, 4'b0000, 32'h0,        1, 3, 1, 0);
      issue(1, 0, 0, 4'b0001, 32'h0,        32'h00007001, 32'h12345678, 32'h00000056, 1, 0, 4'b0000, 32'h0,        1, 3, 1, 0);
      issue(0, 1, 0, 4'b1111, 32'hDEADBEEF, 32'h00008000, 32'h0,        32'h00008000, 2, 0, 4'b1111, 32'hDEADBEEF, 2, 4, 0, 0);
      issue(0, 1, 0, 4'b0001, 32'h000000A5, 32'h00009001, 32'h0,        32'h00009001, 1, 1, 4'b0010, 32'hA5A5A5A5, 1, 2, 0, 0);
      issue(1, 0, 1, 4'b1111, 32'h0,        32'h0000A000, 32'h87654321, 32'h87654321, 2, 1, 4'b0000, 32'h0,        2, 3, 1, 0);
      issue(0, 0, 0, 4'b0011, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1, 0, 4'b0000, 32'h0,        0, 0, 1, 0);
      inst_valid = 0;
      repeat (2) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
